softmax_seq: RTL and testbench

- Multi-pass sequencer for the 4-lane, 16-bit softmax datapath. It lets one command normalise a vector longer than 4 elements.
- Accepts a command (source base, destination base, chunk count, tail lane count) and walks the vector three times: MAX reduction, exp-SUM accumulation, OUT (log-subtract/exp).
- Between passes it inserts pipeline drains and a log-evaluation wait.
- Generates source read addresses, datapath qualifiers (op, first, last, lane mask) and destination write strobes.

---
 rtl/softmax_seq_pkg.sv | 49 ++++
 rtl/softmax_seq_dly.sv | 41 ++++
 rtl/softmax_seq.sv | 184 ++++++++++++++++++
 tb/tb_softmax_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_seq_pkg.sv
// Shared types for the softmax pass sequencer: datapath op codes, FSM states, lane qualifiers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package softmax_seq_pkg;

    localparam int NUM       = 4;
    localparam int DATAWIDTH = 16;

    typedef logic [DATAWIDTH-1:0] elem_t;
    typedef elem_t [NUM-1:0]      vec_t;

    typedef enum logic [1:0] {
        OP_MAX = 2'd0,
        OP_SUM = 2'd1,
        OP_OUT = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAX,
        ST_DRAIN1,
        ST_SUM,
        ST_DRAIN2,
        ST_LOG,
        ST_OUT,
        ST_FLUSH
    } state_t;

    // Per-chunk qualifiers that travel alongside the read data
    typedef struct packed {
        op_t            op;
        logic           first;
        logic           last;
        logic [NUM-1:0] mask;
    } qual_t;

    // Lane enables for the final chunk; a tail of 0 means the chunk is full
    function automatic logic [NUM-1:0] tail_mask(input logic [1:0] tail);
        logic [NUM-1:0] m;
        case (tail)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/softmax_seq_dly.sv
// Fixed-depth shift register carrying a valid bit and a payload.
// Latency: DEPTH cycles from in_vld/in_dat to out_vld/out_dat.
// Backpressure: none; kill flushes every stage on the next edge.
module softmax_seq_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         kill,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    logic [DEPTH-1:0]        vld_sr;
    logic [DEPTH-1:0][W-1:0] dat_sr;

    // Shift one stage per cycle; kill empties the whole line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else if (kill) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else begin
            vld_sr[0] <= in_vld;
            dat_sr[0] <= in_dat;
            for (int k = 1; k < DEPTH; k++) begin
                vld_sr[k] <= vld_sr[k-1];
                dat_sr[k] <= dat_sr[k-1];
            end
        end
    end

    assign out_vld = vld_sr[DEPTH-1];
    assign out_dat = dat_sr[DEPTH-1];

endmodule

// File: rtl/softmax_seq.sv
// Three-pass (MAX, SUM, OUT) sequencer for the 4-lane softmax datapath; SOFTMAX_SEQ_PERF_EN adds perf_cycles.
// Latency: done arrives 3N+3(RD_LAT+DP_LAT)+LOG_LAT+1 cycles after accept; dp_* lag rd_en by RD_LAT.
// Backpressure: cmd_ready low while busy, requester holds cmd_valid; no stall inside a command.
module softmax_seq
    import softmax_seq_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int RD_LAT  = 1,
    parameter int DP_LAT  = 2,
    parameter int LOG_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rd_base,
    input  logic [ADDR_W-1:0] cmd_wr_base,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic [1:0]        cmd_tail,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              dp_valid,
    output logic [1:0]        dp_op,
    output logic              dp_first,
    output logic              dp_last,
    output logic [3:0]        dp_mask,
    output logic              log_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
`ifdef SOFTMAX_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int D  = RD_LAT + DP_LAT;
    localparam int CW = (CNT_W > 16) ? CNT_W : 16;
    localparam int QW = $bits(qual_t);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] rd_base_q, wr_base_q;
    logic [CNT_W-1:0]  len_q;
    logic [1:0]        tail_q;
    logic              done_q, err_q;

    logic              accept, kill, last_chunk, d_end, l_end;
    logic              iss_vld;
    qual_t             iss_q, dp_q;
    logic [CNT_W-1:0]  iss_idx, dp_idx, wr_idx;
    logic              wr_in_vld;

    assign accept     = cmd_valid && (state_q == ST_IDLE);
    assign kill       = abort && (state_q != ST_IDLE);
    assign last_chunk = (cnt_q == CW'(len_q) - CW'(1));
    assign d_end      = (cnt_q == CW'(D - 1));
    assign l_end      = (cnt_q == CW'(LOG_LAT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: walk the passes, abort wins from any active state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept && cmd_len != '0) state_d = ST_MAX;
            ST_MAX:    if (last_chunk) state_d = ST_DRAIN1;
            ST_DRAIN1: if (d_end)      state_d = ST_SUM;
            ST_SUM:    if (last_chunk) state_d = ST_DRAIN2;
            ST_DRAIN2: if (d_end)      state_d = ST_LOG;
            ST_LOG:    if (l_end)      state_d = ST_OUT;
            ST_OUT:    if (last_chunk) state_d = ST_FLUSH;
            ST_FLUSH:  if (d_end)      state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    // Command capture and the shared chunk/wait counter, restarted on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_base_q <= '0;
            wr_base_q <= '0;
            len_q     <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                rd_base_q <= cmd_rd_base;
                wr_base_q <= cmd_wr_base;
                len_q     <= cmd_len;
                tail_q    <= cmd_tail;
            end
            if (state_q == ST_IDLE || state_d != state_q) cnt_q <= '0;
            else                                         cnt_q <= cnt_q + CW'(1);
        end
    end

    // Completion pulses: normal end of FLUSH, or an empty command rejected at accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FLUSH && d_end && !abort) || (accept && cmd_len == '0);
            err_q  <= accept && (cmd_len == '0);
        end
    end

    // Output decode: issue-cycle qualifiers and the ln kick-off
    always_comb begin
        iss_vld   = 1'b0;
        iss_q     = '0;
        iss_idx   = '0;
        log_start = 1'b0;
        case (state_q)
            ST_MAX: begin iss_vld = 1'b1; iss_q.op = OP_MAX; end
            ST_SUM: begin iss_vld = 1'b1; iss_q.op = OP_SUM; end
            ST_OUT: begin iss_vld = 1'b1; iss_q.op = OP_OUT; end
            ST_LOG: log_start = (cnt_q == '0);
            default: ;
        endcase
        if (iss_vld) begin
            iss_idx     = cnt_q[CNT_W-1:0];
            iss_q.first = (cnt_q == '0);
            iss_q.last  = last_chunk;
            iss_q.mask  = last_chunk ? tail_mask(tail_q) : '1;
        end
    end

    assign rd_en   = iss_vld;
    assign rd_addr = iss_vld ? rd_base_q + ADDR_W'(iss_idx) : '0;

    softmax_seq_dly #(.DEPTH(RD_LAT), .W(QW + CNT_W)) u_rd_dly (
        .clk     (clk),
        .reset   (reset),
        .kill    (kill),
        .in_vld  (iss_vld),
        .in_dat  ({iss_q, iss_idx}),
        .out_vld (dp_valid),
        .out_dat ({dp_q, dp_idx})
    );

    // Only OUT-pass chunks produce a destination write
    assign wr_in_vld = dp_valid && (dp_q.op == OP_OUT);

    softmax_seq_dly #(.DEPTH(DP_LAT), .W(CNT_W)) u_wr_dly (
        .clk     (clk),
        .reset   (reset),
        .kill    (kill),
        .in_vld  (wr_in_vld),
        .in_dat  (dp_idx),
        .out_vld (wr_en),
        .out_dat (wr_idx)
    );

    assign wr_addr   = wr_en ? wr_base_q + ADDR_W'(wr_idx) : '0;
    assign dp_op     = dp_q.op;
    assign dp_first  = dp_q.first;
    assign dp_last   = dp_q.last;
    assign dp_mask   = dp_q.mask;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = !busy;
    assign done      = done_q;
    assign err       = err_q;

`ifdef SOFTMAX_SEQ_PERF_EN
    // Busy-cycle counter, zeroed at accept and frozen while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      perf_cycles <= '0;
        else if (accept) perf_cycles <= '0;
        else if (busy)   perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_softmax_seq.sv
module tb_softmax_seq;

    localparam int D = 3;
    localparam int L = 3;
    localparam int RDL = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_rd_base, cmd_wr_base;
    logic [7:0] cmd_len;
    logic [1:0] cmd_tail;
    logic       abort;
    logic       busy, done, err, rd_en, dp_valid, dp_first, dp_last, log_start, wr_en;
    logic [9:0] rd_addr, wr_addr;
    logic [1:0] dp_op;
    logic [3:0] dp_mask;
`ifdef SOFTMAX_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    softmax_seq dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rd_base (cmd_rd_base),
        .cmd_wr_base (cmd_wr_base),
        .cmd_len     (cmd_len),
        .cmd_tail    (cmd_tail),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .dp_valid    (dp_valid),
        .dp_op       (dp_op),
        .dp_first    (dp_first),
        .dp_last     (dp_last),
        .dp_mask     (dp_mask),
        .log_start   (log_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr)
`ifdef SOFTMAX_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    typedef struct packed {
        logic       cmd_ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       rd_en;
        logic [9:0] rd_addr;
        logic       dp_valid;
        logic [1:0] dp_op;
        logic       dp_first;
        logic       dp_last;
        logic [3:0] dp_mask;
        logic       log_start;
        logic       wr_en;
        logic [9:0] wr_addr;
    } obs_t;

    typedef struct {
        logic [9:0] rb;
        logic [9:0] wb;
        int         len;
        int         tail;
        int         exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[6];
    obs_t idle_obs;

    function automatic obs_t sample();
        obs_t o;
        o.cmd_ready = cmd_ready; o.busy = busy; o.done = done; o.err = err;
        o.rd_en = rd_en; o.rd_addr = rd_addr;
        o.dp_valid = dp_valid; o.dp_op = dp_op; o.dp_first = dp_first;
        o.dp_last = dp_last; o.dp_mask = dp_mask;
        o.log_start = log_start; o.wr_en = wr_en; o.wr_addr = wr_addr;
        return o;
    endfunction

    // Qualifier fields only matter while their strobe is high
    function automatic obs_t norm(obs_t o);
        obs_t r = o;
        if (!r.rd_en) r.rd_addr = '0;
        if (!r.dp_valid) begin
            r.dp_op = '0; r.dp_first = 1'b0; r.dp_last = 1'b0; r.dp_mask = '0;
        end
        if (!r.wr_en) r.wr_addr = '0;
        return r;
    endfunction

    // Expected outputs in cycle c after accept, from the pass timing formulas
    function automatic obs_t model(int c, int n, int tail, logic [9:0] rb, logic [9:0] wb);
        obs_t o = '0;
        int s[3];
        int done_c;
        int i;
        s[0] = 1;
        s[1] = n + D + 1;
        s[2] = 2*n + 2*D + L + 1;
        done_c = (n == 0) ? 1 : 3*n + 3*D + L + 1;
        o.cmd_ready = (c >= done_c);
        o.busy      = (c < done_c);
        o.done      = (c == done_c);
        o.err       = (n == 0) && (c == 1);
        if (n > 0) begin
            for (int p = 0; p < 3; p++) begin
                i = c - s[p];
                if (i >= 0 && i < n) begin
                    o.rd_en = 1'b1;
                    o.rd_addr = rb + 10'(i);
                end
                i = c - RDL - s[p];
                if (i >= 0 && i < n) begin
                    o.dp_valid = 1'b1;
                    o.dp_op    = 2'(p);
                    o.dp_first = (i == 0);
                    o.dp_last  = (i == n - 1);
                    o.dp_mask  = (i == n - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
                end
            end
            o.log_start = (c == 2*n + 2*D + 1);
            i = c - D - s[2];
            if (i >= 0 && i < n) begin
                o.wr_en = 1'b1;
                o.wr_addr = wb + 10'(i);
            end
        end
        return o;
    endfunction

    task automatic check_obs(string name, int c, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
        end
    endtask

    task automatic start_cmd(vec_t v);
        @(posedge clk); #1;
        cmd_rd_base = v.rb;
        cmd_wr_base = v.wb;
        cmd_len     = 8'(v.len);
        cmd_tail    = 2'(v.tail);
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic run_vec(string name, vec_t v);
        int first_done = -1;
        obs_t o;
        start_cmd(v);
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            @(negedge clk);
            o = sample();
            if (o.done && first_done < 0) first_done = c;
            check_obs(name, c, norm(o), norm(model(c, v.len, v.tail, v.rb, v.wb)));
        end
        checks++;
        if (first_done != v.exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, first_done, v.exp_done);
        end
`ifdef SOFTMAX_SEQ_PERF_EN
        checks++;
        if (perf_cycles != 32'(v.exp_done - 1)) begin
            errors++;
            $display("FAIL %s perf_cycles: got %0d expected %0d", name, perf_cycles, v.exp_done - 1);
        end
`endif
    endtask

    initial begin
        obs_t o;
        vec_t hv;
        idle_obs = '0;
        idle_obs.cmd_ready = 1'b1;

        vecs[0] = '{10'h010, 10'h020, 1, 0, 16};
        vecs[1] = '{10'h100, 10'h200, 4, 3, 25};
        vecs[2] = '{10'h000, 10'h000, 0, 0, 1};
        vecs[3] = '{10'h3FE, 10'h050, 4, 0, 25};
        vecs[4] = '{10'h005, 10'h3FD, 5, 1, 28};
        vecs[5] = '{10'h020, 10'h030, 2, 2, 19};

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_rd_base = '0; cmd_wr_base = '0;
        cmd_len = '0; cmd_tail = '0; abort = 1'b0;
        #12;
        check_obs("reset_state", 0, sample(), idle_obs);
        @(negedge clk); reset = 1'b1;

        for (int k = 0; k < 6; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // Abort on the first SUM issue cycle of an N=4 command
        hv = '{10'h040, 10'h080, 4, 0, 25};
        start_cmd(hv);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_obs("abort_pre", c, norm(sample()), norm(model(c, 4, 0, hv.rb, hv.wb)));
        end
        @(posedge clk); #1; abort = 1'b1;
        @(negedge clk);
        check_obs("abort_cycle", 8, norm(sample()), norm(model(8, 4, 0, hv.rb, hv.wb)));
        @(posedge clk); #1; abort = 1'b0;
        for (int c = 9; c <= 30; c++) begin
            @(negedge clk);
            check_obs("abort_idle", c, norm(sample()), idle_obs);
        end
        run_vec("after_abort", vecs[5]);

        // Reset pulled low during the OUT pass of an N=2 command
        hv = '{10'h060, 10'h070, 2, 0, 19};
        start_cmd(hv);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check_obs("rst_pre", c, norm(sample()), norm(model(c, 2, 0, hv.rb, hv.wb)));
        end
        #2 reset = 1'b0;
        #1 check_obs("rst_async", 14, sample(), idle_obs);
        @(negedge clk); reset = 1'b1;
        for (int c = 15; c <= 30; c++) begin
            @(negedge clk);
            check_obs("rst_idle", c, norm(sample()), idle_obs);
        end

        // cmd_valid held through a whole command: second accept lands on the done cycle
        hv = '{10'h0A0, 10'h0B0, 1, 0, 16};
        @(posedge clk); #1;
        cmd_rd_base = hv.rb; cmd_wr_base = hv.wb; cmd_len = 8'd1; cmd_tail = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            o = sample();
            check_obs("held_cmd", c, norm(o),
                      norm(model((c <= 16) ? c : c - 16, 1, 0, hv.rb, hv.wb)));
            if (c == 16) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
